// File: rtl/inner_dot_vec_mac.sv
// Streaming signed dot-product MAC: LANES products per beat, VEC_BEATS beats per
// vector, then round/shift, optional ReLU and saturation into a held output register.
module inner_dot_vec_mac #(
  parameter int DATA_W    = 8,
  parameter int LANES     = 3,
  parameter int VEC_BEATS = 3,
  parameter int SUM_WIDTH = 20,
  parameter int SHIFT     = 8,
  parameter int OUT_W     = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clr,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*DATA_W-1:0]     data,
  input  logic [LANES*DATA_W-1:0]     weight,
  input  logic                        rnd,
  input  logic                        relu,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [SUM_WIDTH-1:0] sum_raw,
  output logic signed [OUT_W-1:0]     ans,
  output logic                        sat
);

  localparam int CNT_W = (VEC_BEATS > 1) ? $clog2(VEC_BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(VEC_BEATS - 1);
  localparam int QW = SUM_WIDTH + 1;
  localparam logic signed [QW-1:0] RND_BIAS = QW'(64'sd1 <<< (SHIFT - 1));
  localparam logic signed [QW-1:0] OUT_MAX  = QW'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [QW-1:0] OUT_MIN  = QW'(-(64'sd1 <<< (OUT_W - 1)));

  if (SUM_WIDTH < 2*DATA_W + $clog2(LANES*VEC_BEATS)) begin : g_sum_width_check
    $error("inner_dot_vec_mac: SUM_WIDTH too narrow for DATA_W, LANES and VEC_BEATS");
  end
  if (SHIFT < 1 || SHIFT > SUM_WIDTH - 1) begin : g_shift_check
    $error("inner_dot_vec_mac: SHIFT must lie in 1..SUM_WIDTH-1");
  end

  function automatic logic signed [SUM_WIDTH-1:0] lane_prod(
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    logic signed [2*DATA_W-1:0] ea;
    logic signed [2*DATA_W-1:0] eb;
    logic signed [2*DATA_W-1:0] p;
    ea = (2*DATA_W)'($signed(a));
    eb = (2*DATA_W)'($signed(b));
    p  = ea * eb;
    return SUM_WIDTH'(p);
  endfunction

  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        s1_valid_q, s1_valid_d;
  logic                        s1_first_q, s1_first_d;
  logic                        s1_last_q, s1_last_d;
  logic                        s1_rnd_q, s1_rnd_d;
  logic                        s1_relu_q, s1_relu_d;
  logic signed [SUM_WIDTH-1:0] s1_sum_q, s1_sum_d;
  logic signed [SUM_WIDTH-1:0] acc_q, acc_d;
  logic                        out_valid_q, out_valid_d;
  logic signed [SUM_WIDTH-1:0] sum_raw_q, sum_raw_d;
  logic signed [OUT_W-1:0]     ans_q, ans_d;
  logic                        sat_q, sat_d;

  logic signed [SUM_WIDTH-1:0] beat_sum_s;
  logic signed [SUM_WIDTH-1:0] total_s;
  logic signed [QW-1:0]        biased_s;
  logic signed [QW-1:0]        q_s;
  logic signed [QW-1:0]        q_relu_s;
  logic signed [OUT_W-1:0]     ans_s;
  logic                        sat_s;
  logic                        stall_s;
  logic                        accept_s;
  logic                        s2_fire_s;
  logic                        load_s;

  // Lane products of the presented beat, summed at full accumulator width.
  always_comb begin
    beat_sum_s = '0;
    for (int i = 0; i < LANES; i++) begin
      beat_sum_s = beat_sum_s + lane_prod(data[i*DATA_W +: DATA_W], weight[i*DATA_W +: DATA_W]);
    end
  end

  // Running total and requantisation of the vector that stage 1 is completing.
  always_comb begin
    if (s1_first_q) begin
      total_s = s1_sum_q;
    end else begin
      total_s = acc_q + s1_sum_q;
    end
    if (s1_rnd_q) begin
      biased_s = QW'(total_s) + RND_BIAS;
    end else begin
      biased_s = QW'(total_s);
    end
    q_s = biased_s >>> SHIFT;
    if (s1_relu_q && q_s[QW-1]) begin
      q_relu_s = '0;
    end else begin
      q_relu_s = q_s;
    end
    if (q_relu_s > OUT_MAX) begin
      ans_s = OUT_MAX[OUT_W-1:0];
      sat_s = 1'b1;
    end else if (q_relu_s < OUT_MIN) begin
      ans_s = OUT_MIN[OUT_W-1:0];
      sat_s = 1'b1;
    end else begin
      ans_s = q_relu_s[OUT_W-1:0];
      sat_s = 1'b0;
    end
  end

  // Handshake, stall and next-state for the beat pipe, accumulator and output register.
  always_comb begin
    stall_s   = s1_valid_q & s1_last_q & out_valid_q & ~out_ready;
    accept_s  = in_valid & ~stall_s & ~clr;
    s2_fire_s = s1_valid_q & ~stall_s & ~clr;
    load_s    = s2_fire_s & s1_last_q;

    cnt_d       = cnt_q;
    s1_valid_d  = s1_valid_q;
    s1_first_d  = s1_first_q;
    s1_last_d   = s1_last_q;
    s1_rnd_d    = s1_rnd_q;
    s1_relu_d   = s1_relu_q;
    s1_sum_d    = s1_sum_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    sum_raw_d   = sum_raw_q;
    ans_d       = ans_q;
    sat_d       = sat_q;

    if (clr) begin
      cnt_d      = '0;
      s1_valid_d = 1'b0;
      acc_d      = '0;
    end else if (!stall_s) begin
      s1_valid_d = accept_s;
      if (accept_s) begin
        s1_sum_d   = beat_sum_s;
        s1_first_d = (cnt_q == '0);
        s1_last_d  = (cnt_q == LAST_CNT);
        s1_rnd_d   = rnd;
        s1_relu_d  = relu;
        if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        cnt_d = cnt_q;
      end
      if (s2_fire_s) begin
        if (s1_last_q) begin
          acc_d = '0;
        end else begin
          acc_d = total_s;
        end
      end else begin
        acc_d = acc_q;
      end
    end else begin
      cnt_d = cnt_q;
    end

    // A new result may replace the one being consumed on the same edge.
    if (load_s) begin
      out_valid_d = 1'b1;
      sum_raw_d   = total_s;
      ans_d       = ans_s;
      sat_d       = sat_s;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_rnd_q    <= 1'b0;
      s1_relu_q   <= 1'b0;
      s1_sum_q    <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      sum_raw_q   <= '0;
      ans_q       <= '0;
      sat_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      s1_valid_q  <= s1_valid_d;
      s1_first_q  <= s1_first_d;
      s1_last_q   <= s1_last_d;
      s1_rnd_q    <= s1_rnd_d;
      s1_relu_q   <= s1_relu_d;
      s1_sum_q    <= s1_sum_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      sum_raw_q   <= sum_raw_d;
      ans_q       <= ans_d;
      sat_q       <= sat_d;
    end
  end

  assign in_ready  = ~stall_s;
  assign out_valid = out_valid_q;
  assign sum_raw   = sum_raw_q;
  assign ans       = ans_q;
  assign sat       = sat_q;

endmodule

// File: doc/inner_dot_vec_mac.md
INNER_DOT_VEC_MAC -- requirements
Module: inner_dot_vec_mac

Interface
- REQ-001: Parameter DATA_W, default 8; signed width of each data and weight element.
- REQ-002: Parameter LANES, default 3; data/weight pairs multiplied per accepted beat.
- REQ-003: Parameter VEC_BEATS, default 3; beats per dot product (default 3x3 = 9 taps).
- REQ-004: Parameter SUM_WIDTH, default 20; signed accumulator and raw-result width.
- REQ-005: Parameter SHIFT, default 8; arithmetic right shift applied for requantisation; range 1..SUM_WIDTH-1.
- REQ-006: Parameter OUT_W, default 8; signed width of the requantised output.
- REQ-007: clk  input  1  single clock; all state updates on rising edge.
- REQ-008: rst_n  input  1  asynchronous, active-low reset.
- REQ-009: clr  input  1  synchronous flush; discards the partial vector and the stage-1 beat.
- REQ-010: in_valid  input  1  beat valid.
- REQ-011: in_ready  output  1  beat accepted when in_valid and in_ready are both high.
- REQ-012: data  input  LANES*DATA_W  packed signed elements; lane i at bits [i*DATA_W +: DATA_W].
- REQ-013: weight  input  LANES*DATA_W  packed signed weights, same lane packing as data.
- REQ-014: rnd  input  1  1 = round half up before shifting; 0 = floor; sampled with the final beat.
- REQ-015: relu  input  1  1 = clamp negative results to 0 before saturation; sampled with the final beat.
- REQ-016: out_valid  output  1  result valid; held until out_ready.
- REQ-017: out_ready  input  1  result consumed when out_valid and out_ready are both high.
- REQ-018: sum_raw  output  SUM_WIDTH  full-precision signed dot product.
- REQ-019: ans  output  OUT_W  requantised, saturated result.
- REQ-020: sat  output  1  high when ans was clipped to the OUT_W range.

Function
- REQ-021: Stage 1 registers the signed sum of LANES products (each product 2*DATA_W bits), together with a valid bit and a last bit, when a beat is accepted.
- REQ-022: A beat counter runs 0..VEC_BEATS-1, increments per accepted beat, and wraps to 0 after the last beat; last = (count == VEC_BEATS-1).
- REQ-023: Stage 2 loads the accumulator with the stage-1 sum on the first beat of a vector; otherwise it adds the stage-1 sum to the accumulator.
- REQ-024: Elaboration shall fail if SUM_WIDTH < 2*DATA_W + clog2(LANES*VEC_BEATS); the sum therefore never wraps.
- REQ-025: On a last beat in stage 2, with the output register free (out_valid low, or out_ready high), the block loads sum_raw, ans and sat, sets out_valid, and restarts the accumulator for the next vector.
- REQ-026: Requantisation: q = (acc + (rnd ? 2^(SHIFT-1) : 0)) >>> SHIFT; then if relu and q < 0, q = 0; then saturate q to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; sat = 1 iff clipped.
- REQ-027: Stall = stage-1 valid AND last AND out_valid AND NOT out_ready; during stall stage 1, the counter and the accumulator hold, and in_ready = NOT stall.
- REQ-028: Latency: final-beat handshake in cycle c -> out_valid high in cycle c+2; throughput is one beat per cycle with no bubble between vectors.
- REQ-029: out_valid falls after the handshake unless a new result loads on the same edge, in which case it stays high with the new values.
- REQ-030: clr clears the counter, stage-1 valid and the accumulator; it does not affect a pending output; a beat presented with clr is discarded; clr has priority over stall.

Reset
- REQ-031: rst_n low asynchronously clears out_valid, sum_raw, ans, sat, the accumulator, the counter and stage-1 valid to 0.
- REQ-032: in_ready reads 1 during and after reset.
- REQ-033: Reset mid-vector discards the partial sum; the first beat after reset starts a new vector.

Verification (defaults)
- REQ-034: 3 beats, all lanes data=127, weight=127, rnd=0, relu=0 -> sum_raw=145161, ans=127, sat=1, out_valid 2 cycles after the 3rd handshake.
- REQ-035: 3 beats, data=-128, weight=127 -> sum_raw=-146304, ans=-128, sat=1; same stimulus with relu=1 -> ans=0, sat=0.
- REQ-036: Beat 1 lanes (64,2),(64,2),(64,2), beats 2-3 all zero -> sum_raw=384; rnd=0 gives ans=1, rnd=1 gives ans=2, sat=0.
- REQ-037: Back-to-back vectors with out_ready=0 -> in_ready drops while the 2nd final beat is in stage 1; raising out_ready delivers result 1 then result 2 in order, none lost or duplicated.
- REQ-038: clr after 2 beats, then 3 beats of data=1, weight=1 -> sum_raw=9, ans=0; rst_n pulsed mid-vector -> all outputs 0, next full vector correct.
